context_loader: RTL
===================

// Module: context_loader
// PURPOSE
// Host-side writer for the CGRA context control unit (CCU). Accepts a 32-bit command stream over
// a valid/ready handshake and turns it into CCU context-memory writes (WR_EN/ADDR/DATA). It starts
// execution with a LOAD_EN pulse and gates the CCU run enable. Sits between the host/DMA port and
// the CCU; it is the only master of the CCU write/load ports.
// PARAMETERS
// CONTEXT_ADDR_WIDTH     8    CCU context address width; CCU entry width is CONTEXT_ADDR_WIDTH+2
// CONTEXT_MEMORY_LENGTH  256  number of valid context entries (<= 2**CONTEXT_ADDR_WIDTH)
// PORTS
// CLK_I          in   1       clock, rising edge
// RST_N_I        in   1       asynchronous active-low reset
// CMD_VALID_I    in   1       host word valid
// CMD_READY_O    out  1       loader ready; transfer on VALID&&READY
// CMD_DATA_I     in   32      header or data word
// CLR_ERR_I      in   1       synchronous clear of ERR_O
// CCU_WR_EN_O    out  1       context-memory write strobe
// CCU_ADDR_O     out  CAW     write address, or start address while CCU_LOAD_EN_O is high
// CCU_DATA_O     out  CAW+2   context entry {uncond,cond,target}
// CCU_LOAD_EN_O  out  1       load start address into the CCU counter
// CCU_EN_O       out  1       CCU run enable
// BUSY_O         out  1       high in any state other than IDLE
// ERR_O          out  1       sticky protocol/range error
// BEHAVIOUR
// - Header word: [31:30] op (00 NOP, 01 WRITE, 10 START, 11 STOP).
//   [16+CAW-1:16] LEN = burst words - 1. [CAW-1:0] ADDR.
// - Data word: only bits [CAW+1:0] are used; the upper bits are ignored.
// - States: IDLE, WRITE, LOAD, RUN. Reset puts the FSM in IDLE.
// - Reset values: all outputs 0 except CMD_READY_O, which is 1.
//   An async reset mid-burst or mid-run discards all state. Entries already written stay in CCU memory.
// - IDLE: READY=1.
//   - WRITE header: latch ADDR and LEN, then go to WRITE.
//   - START header: latch ADDR, then go to LOAD.
//   - NOP and STOP are consumed with no effect.
// - WRITE: READY=1. Each accepted data word drives CCU_WR_EN_O=1 for exactly one cycle, on the
//   cycle after the handshake (registered outputs), with the current address and that word.
//   - The address then increments modulo 2**CAW. The remaining count decrements.
//   - After word LEN+1 the FSM returns to IDLE.
//   - If the address is >= CONTEXT_MEMORY_LENGTH, the write is suppressed and ERR_O is set.
//     The burst still consumes its words.
//   - Back-to-back words give one write per cycle. A VALID gap inserts no write.
// - LOAD: READY=0 for 1 cycle. CCU_LOAD_EN_O=1, CCU_EN_O=1, CCU_ADDR_O=start ADDR, WR_EN=0.
//   Next state is RUN.
// - RUN: READY=1, CCU_EN_O=1.
//   - STOP: CCU_EN_O=0 from the next cycle, then IDLE.
//   - NOP: ignored.
//   - WRITE or START: the header is dropped and ERR_O is set. The CCU keeps running.
// - CCU_WR_EN_O and CCU_LOAD_EN_O are never high in the same cycle.
// - CCU_ADDR_O holds its last value when unused.
// - ERR_O is sticky until CLR_ERR_I. If set and clear occur in the same cycle, set wins.
// - LEN counter width is CAW bits, so the maximum burst is 2**CAW words.
// CONFIGURATION
// - CONTEXT_LOADER_CHECKSUM_EN defined: each WRITE burst is followed by one extra checksum word.
//   - The checksum is the XOR of bits [CAW+1:0] of all data words in the burst, compared in bits [CAW+1:0].
//   - While the checksum word is pending, the FSM stays in WRITE.
//   - A mismatch sets ERR_O. Writes already issued are not undone.
// - Macro undefined: no checksum word is expected and the XOR logic is absent.
// TESTING
// - Reset: after RST_N_I is deasserted -> READY=1, all other outputs 0, BUSY_O=0.
// - WRITE ADDR=0x10, LEN=2, data 0x3FF/0x155/0x001 back-to-back -> 3 single-cycle WR_EN at
//   addr 0x10..0x12 with those data values, then IDLE.
// - LENGTH=200, WRITE ADDR=199, LEN=1 -> one write at 199; write at 200 suppressed; ERR_O=1;
//   CLR_ERR_I clears it.
// - START ADDR=0x05 -> one cycle of LOAD_EN=1, EN=1, ADDR=0x05, READY=0; then RUN with EN=1.
//   STOP -> EN=0, IDLE.
// - In RUN, send a WRITE header -> no WR_EN, ERR_O=1, EN stays 1.
//   Async reset mid-burst -> IDLE immediately.
// - With CONTEXT_LOADER_CHECKSUM_EN, burst 0x003,0x005 + checksum 0x006 -> ERR_O=0.
//   Checksum 0x007 -> ERR_O=1.

Source files
------------

// File: rtl/context_loader.sv
// Host command-stream writer for the CGRA context control unit (CCU write/load/run master).
// Optional feature macro: CONTEXT_LOADER_CHECKSUM_EN (trailing XOR checksum word per WRITE burst).
module context_loader #(
  parameter int CONTEXT_ADDR_WIDTH    = 8,
  parameter int CONTEXT_MEMORY_LENGTH = 256
) (
  input  logic                          CLK_I,
  input  logic                          RST_N_I,
  input  logic                          CMD_VALID_I,
  output logic                          CMD_READY_O,
  input  logic [31:0]                   CMD_DATA_I,
  input  logic                          CLR_ERR_I,
  output logic                          CCU_WR_EN_O,
  output logic [CONTEXT_ADDR_WIDTH-1:0] CCU_ADDR_O,
  output logic [CONTEXT_ADDR_WIDTH+1:0] CCU_DATA_O,
  output logic                          CCU_LOAD_EN_O,
  output logic                          CCU_EN_O,
  output logic                          BUSY_O,
  output logic                          ERR_O
);

  localparam int CAW = CONTEXT_ADDR_WIDTH;
  localparam int DW  = CONTEXT_ADDR_WIDTH + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  // One extra bit so a full-size memory (LENGTH == 2**CAW) never flags a range error.
  localparam logic [CAW:0] C_LIMIT = (CAW+1)'(CONTEXT_MEMORY_LENGTH);

  logic [1:0]     r_state;
  logic [CAW-1:0] r_addr;
  logic [CAW-1:0] r_cnt;
  logic [CAW-1:0] r_ccu_addr;
  logic [DW-1:0]  r_ccu_data;
  logic           r_wr_en;
  logic           r_err;

  logic           w_xfer;
  logic [1:0]     w_op;
  logic [CAW-1:0] w_hdr_addr;
  logic [CAW-1:0] w_hdr_len;
  logic [DW-1:0]  w_word;
  logic           w_in_range;
  logic           w_data_phase;
  logic           w_data_xfer;
  logic           w_ck_phase;
  logic           w_ck_bad;
  logic           w_run_bad;
  logic           w_err_set;
  logic           w_last_word_done;
  logic           w_unused;

  assign w_xfer      = CMD_VALID_I && CMD_READY_O;
  assign w_op        = CMD_DATA_I[31:30];
  assign w_hdr_addr  = CMD_DATA_I[CAW-1:0];
  assign w_hdr_len   = CMD_DATA_I[16+CAW-1:16];
  assign w_word      = CMD_DATA_I[DW-1:0];
  assign w_in_range  = ({1'b0, r_addr} < C_LIMIT);
  assign w_data_xfer = w_xfer && w_data_phase;
  assign w_unused    = ^{CMD_DATA_I[29:16+CAW], CMD_DATA_I[15:DW]};

`ifdef CONTEXT_LOADER_CHECKSUM_EN
  logic          r_ck_pend;
  logic [DW-1:0] r_xor;

  assign w_data_phase     = (r_state == S_WRITE) && !r_ck_pend;
  assign w_ck_phase       = (r_state == S_WRITE) && r_ck_pend;
  assign w_ck_bad         = w_xfer && w_ck_phase && (w_word != r_xor);
  assign w_last_word_done = w_xfer && w_ck_phase;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_ck_pend <= 1'b0;
      r_xor     <= '0;
    end else if (r_state == S_IDLE && w_xfer && w_op == OP_WRITE) begin
      r_ck_pend <= 1'b0;
      r_xor     <= '0;
    end else if (w_data_xfer) begin
      r_xor <= r_xor ^ w_word;
      if (r_cnt == '0) r_ck_pend <= 1'b1;
    end else if (w_xfer && w_ck_phase) begin
      r_ck_pend <= 1'b0;
    end
  end
`else
  assign w_data_phase     = (r_state == S_WRITE);
  assign w_ck_phase       = 1'b0;
  assign w_ck_bad         = 1'b0;
  assign w_last_word_done = w_data_xfer && (r_cnt == '0);
`endif

  assign w_run_bad = w_xfer && (r_state == S_RUN) && (w_op == OP_WRITE || w_op == OP_START);
  assign w_err_set = (w_data_xfer && !w_in_range) || w_run_bad || w_ck_bad;

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_ccu_addr <= '0;
      r_ccu_data <= '0;
      r_wr_en    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_err   <= w_err_set || (r_err && !CLR_ERR_I);
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            case (w_op)
              OP_WRITE: begin
                r_addr  <= w_hdr_addr;
                r_cnt   <= w_hdr_len;
                r_state <= S_WRITE;
              end
              OP_START: begin
                r_ccu_addr <= w_hdr_addr;
                r_state    <= S_LOAD;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
        S_WRITE: begin
          // Out-of-range words still advance address and count so the burst length is honoured.
          if (w_data_xfer) begin
            if (w_in_range) begin
              r_wr_en    <= 1'b1;
              r_ccu_addr <= r_addr;
              r_ccu_data <= w_word;
            end
            r_addr <= r_addr + 1'b1;
            r_cnt  <= r_cnt - 1'b1;
          end
          if (w_last_word_done) r_state <= S_IDLE;
        end
        S_LOAD: r_state <= S_RUN;
        S_RUN: begin
          if (w_xfer && w_op == OP_STOP) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign CMD_READY_O   = (r_state != S_LOAD);
  assign CCU_WR_EN_O   = r_wr_en;
  assign CCU_ADDR_O    = r_ccu_addr;
  assign CCU_DATA_O    = r_ccu_data;
  assign CCU_LOAD_EN_O = (r_state == S_LOAD);
  assign CCU_EN_O      = (r_state == S_LOAD) || (r_state == S_RUN);
  assign BUSY_O        = (r_state != S_IDLE);
  assign ERR_O         = r_err;

endmodule
